// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM state encodings, parity
// mode constants and the parity helper used by both directions.
// Latency: n/a (package). Backpressure: n/a (package).
package uart_pkg;

  // Both the transmitter and receiver oversample each bit by 16 s_ticks.
  localparam int OVERSAMPLE = 16;

  // Parity mode selector values for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  // Parity bit over the low dbit bits of data. Even mode makes the total
  // count of ones (data + parity) even; odd mode makes it odd.
  function automatic logic parity_of(input logic [7:0] data,
                                     input int         dbit,
                                     input int         mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < dbit) x = x ^ data[i];
    end
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises din as start, DBIT data bits (LSB first),
// optional parity and a 1/1.5/2-bit stop period, paced by the 16x s_tick.
// Latency: start bit on tx 1 clk after tx_start is sampled in idle; the
// frame then lasts (1+DBIT+(PARITY!=0))*16+SB_TICK s_ticks.
// Backpressure: none; tx_start is only honoured in idle (tx_busy low),
// requests while busy are dropped.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous active-low reset
//   tx_start     request to send din, sampled only in idle
//   s_tick       one-clk enable at 16x baud from the shared baud generator
//   din          data word, bits [DBIT-1:0] are sent, LSB first
//   tx           registered serial line, idles at 1
//   tx_busy      high in every state except idle
//   tx_done_tick one-clk pulse on the last s_tick of the stop period
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam logic [4:0] BIT_LAST   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST  = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST     = 3'(DBIT - 1);
  localparam logic [7:0] DATA_MASK  = 8'((1 << DBIT) - 1);
  localparam bit         HAS_PARITY = (PARITY != PAR_NONE);

  uart_state_e state_q, state_d;
  logic [4:0]  s_q, s_d;       // s_tick count within the current bit
  logic [2:0]  n_q, n_d;       // data bit index
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UART_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    par_d   = par_q;
    done    = 1'b0;

    case (state_q)
      UART_IDLE: begin
        if (tx_start) begin
          // Capture word and parity together so later din changes cannot
          // leak into the frame.
          shift_d = din & DATA_MASK;
          par_d   = HAS_PARITY ? parity_of(din, DBIT, PARITY) : 1'b0;
          s_d     = '0;
          state_d = UART_START;
        end
      end

      UART_START: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = UART_DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      UART_DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              state_d = HAS_PARITY ? UART_PARITY : UART_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      UART_PARITY: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            state_d = UART_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      UART_STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = UART_IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: state_d = UART_IDLE;
    endcase

    // The line register follows the state being entered, so tx moves on
    // the same edge as the state and is glitch-free.
    case (state_d)
      UART_START:  tx_d = 1'b0;
      UART_DATA:   tx_d = shift_d[0];
      UART_PARITY: tx_d = par_q;
      default:     tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != UART_IDLE);
  assign tx_done_tick = done;

endmodule
